flash_cmd_seq: RTL

FLASH_CMD_SEQ -- requirements
Module: flash_cmd_seq

---
 rtl/flash_seq_pkg.sv | 42 ++++
 rtl/flash_seq_wdog.sv | 47 ++++
 rtl/flash_cmd_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/flash_seq_pkg.sv
// -----------------------------------------------------------------------------
// flash_seq_pkg
// Shared definitions for the flash command sequencer: operation codes, FSM
// state encoding, flash controller status bit position, transfer sizes and
// small op-decode helpers.
// -----------------------------------------------------------------------------
package flash_seq_pkg;

    // Operation codes carried on cmd_op; 5..7 are illegal.
    localparam logic [2:0] OP_READ_WORD   = 3'd0;
    localparam logic [2:0] OP_PROG_WORD   = 3'd1;
    localparam logic [2:0] OP_SECTOR_ERASE = 3'd2;
    localparam logic [2:0] OP_BULK_ERASE  = 3'd3;
    localparam logic [2:0] OP_READ_ID     = 3'd4;

    // Bit of the controller's one-hot state vector that means "idle".
    localparam int unsigned FL_IDLE_BIT = 0;

    // Bytes moved per word transfer.
    localparam int unsigned READ_WORD_BYTES = 4;
    localparam int unsigned PROG_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        WEN_REQ  = 3'd1,
        WEN_WAIT = 3'd2,
        OP_REQ   = 3'd3,
        OP_WAIT  = 3'd4,
        RSP      = 3'd5
    } seq_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_READ_ID;
    endfunction

    // Operations that modify the array need a write-enable phase first.
    function automatic logic op_needs_wen(input logic [2:0] op);
        return (op == OP_PROG_WORD) || (op == OP_SECTOR_ERASE) ||
               (op == OP_BULK_ERASE);
    endfunction

endpackage

// File: rtl/flash_seq_wdog.sv
// -----------------------------------------------------------------------------
// flash_seq_wdog
// Per-phase watchdog for the flash command sequencer. Counts cycles spent in
// the current waiting state and flags a timeout when the count reaches
// TIMEOUT_CYCLES. Only instantiated when FLASH_SEQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   en_i       sequencer is in a request/wait state
//   clr_i      sequencer state changes this cycle
//   timeout_o  count has reached TIMEOUT_CYCLES in the current state
// -----------------------------------------------------------------------------
module flash_seq_wdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd70_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The timeout forces a state change, which clears the count, so the
    // counter never runs past the limit.
    assign timeout_o = en_i && (cnt_q == TIMEOUT_CYCLES);

endmodule

// File: rtl/flash_cmd_seq.sv
// -----------------------------------------------------------------------------
// flash_cmd_seq
// Turns single word-level commands (read, program, sector/bulk erase, read ID)
// into the level-request handshake of the flash controller. Write-type
// operations get a write-enable phase first; each phase raises one request,
// waits for the controller to leave idle, drops it, then waits for idle again.
//
// Optional feature: define FLASH_SEQ_TIMEOUT_EN to add a per-phase watchdog
// (flash_seq_wdog) that aborts a stuck phase with rsp_err after
// TIMEOUT_CYCLES cycles. Without it the sequencer waits indefinitely.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only when idle)
//   cmd_op/addr/wdata      command fields, latched on acceptance
//   rsp_valid/rdata/err    one-cycle completion pulse with result
//   fl_*_rq/_req           level requests to the flash controller
//   fl_*addr/page, sizes   request parameters from the latched command
//   fl_write_data          latched program data
//   fl_state               controller one-hot state, bit 0 = idle
//   fl_read_data_word      controller's assembled read word
// -----------------------------------------------------------------------------
module flash_cmd_seq
    import flash_seq_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd70_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        fl_read_rq,
    output logic        fl_read_id_rq,
    output logic        fl_write_en_req,
    output logic        fl_write_req,
    output logic        fl_sector_erase_req,
    output logic        fl_bulk_erase_req,
    output logic [23:0] fl_read_addr,
    output logic [23:0] fl_write_page,
    output logic [23:0] fl_sector_erase_addr,
    output logic [9:0]  fl_read_size,
    output logic [7:0]  fl_write_size,
    output logic [31:0] fl_write_data,
    input  logic [12:0] fl_state,
    input  logic [31:0] fl_read_data_word
);

    seq_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        fl_idle;
    logic        timeout;

    assign fl_idle = fl_state[FL_IDLE_BIT];

    // Only the idle bit matters to the sequencer.
    logic unused_fl_state;
    assign unused_fl_state = ^fl_state[12:1];

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic in_phase;
    logic state_change;

    assign in_phase     = state_q inside {WEN_REQ, WEN_WAIT, OP_REQ, OP_WAIT};
    assign state_change = (state_d != state_q);

    flash_seq_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .en_i     (in_phase),
        .clr_i    (state_change),
        .timeout_o(timeout)
    );
`else
    assign timeout = 1'b0;

    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    // Next-state and datapath logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            SEQ_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (!op_is_legal(cmd_op)) begin
                        state_d   = RSP;
                        rsp_err_d = 1'b1;
                    end else if (op_needs_wen(cmd_op)) begin
                        state_d = WEN_REQ;
                    end else begin
                        state_d = OP_REQ;
                    end
                end
            end
            // Request states: hold the level until the controller goes busy.
            WEN_REQ: begin
                if (timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else if (!fl_idle) begin
                    state_d = WEN_WAIT;
                end
            end
            WEN_WAIT: begin
                if (timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else if (fl_idle) begin
                    state_d = OP_REQ;
                end
            end
            OP_REQ: begin
                if (timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else if (!fl_idle) begin
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else if (fl_idle) begin
                    state_d = RSP;
                    // READ_ID leaves the ID in the controller; report zero.
                    if (op_q == OP_READ_WORD) begin
                        rsp_rdata_d = fl_read_data_word;
                    end else if (op_q == OP_READ_ID) begin
                        rsp_rdata_d = '0;
                    end
                end
            end
            RSP: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: all registers, including the latched command fields, reset so an
    // abandoned command leaves nothing visible on the flash-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEQ_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            // High exactly for the single cycle spent in RSP.
            rsp_valid_q <= (state_d == RSP);
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request levels: decoded from the current state; a timing-out phase drops
    // its request in the same cycle it leaves for RSP.
    always_comb begin
        fl_read_rq          = 1'b0;
        fl_read_id_rq       = 1'b0;
        fl_write_en_req     = 1'b0;
        fl_write_req        = 1'b0;
        fl_sector_erase_req = 1'b0;
        fl_bulk_erase_req   = 1'b0;

        if (!timeout) begin
            if (state_q == WEN_REQ) begin
                fl_write_en_req = 1'b1;
            end else if (state_q == OP_REQ) begin
                case (op_q)
                    OP_READ_WORD:    fl_read_rq          = 1'b1;
                    OP_PROG_WORD:    fl_write_req        = 1'b1;
                    OP_SECTOR_ERASE: fl_sector_erase_req = 1'b1;
                    OP_BULK_ERASE:   fl_bulk_erase_req   = 1'b1;
                    OP_READ_ID:      fl_read_id_rq       = 1'b1;
                    default:         ;
                endcase
            end
        end
    end

    assign cmd_ready            = (state_q == SEQ_IDLE);
    assign rsp_valid            = rsp_valid_q;
    assign rsp_err              = rsp_err_q;
    assign rsp_rdata            = rsp_rdata_q;
    assign fl_read_addr         = addr_q;
    assign fl_write_page        = addr_q;
    assign fl_sector_erase_addr = addr_q;
    assign fl_read_size         = 10'(READ_WORD_BYTES);
    assign fl_write_size        = 8'(PROG_WORD_BYTES);
    assign fl_write_data        = wdata_q;

endmodule
